// File: rtl/io_bridge_if.sv
// ---------------------------------------------------------------------------
// io_bridge_if
// Groups the CPU MEM-stage data-port signals that feed io_bridge.
//   Bus_addr  : byte address driven by the CPU
//   Bus_wen   : one-cycle store strobe
//   Bus_wdata : store data
//   Bus_rdata : combinational load data returned by the bridge
// Modports: master (CPU side) and slave (bridge side).
// ---------------------------------------------------------------------------
interface io_bridge_if;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  modport master (
    output Bus_addr,
    output Bus_wen,
    output Bus_wdata,
    input  Bus_rdata
  );

  modport slave (
    input  Bus_addr,
    input  Bus_wen,
    input  Bus_wdata,
    output Bus_rdata
  );
endinterface : io_bridge_if

// File: rtl/io_bridge.sv
// ---------------------------------------------------------------------------
// io_bridge
// Memory-mapped bridge between the CPU MEM-stage data port and the board
// resources: data RAM, LEDs, switches, buttons, 8-digit 7-segment display
// and a prescaled timer. Decode and read data are combinational so a load
// completes in the CPU's MEM cycle; all peripheral state is registered.
//
// Parameters:
//   SCAN_DIV  : cpu_clk cycles each display digit stays lit
//   TIMER_RST : reset value of the timer count register
//
// Ports:
//   cpu_clk, cpu_rst (async, active-low)
//   bus        : io_bridge_if.slave (Bus_addr/Bus_wen/Bus_wdata/Bus_rdata)
//   dram_addr/dram_we/dram_wdata/dram_rdata : data RAM port
//   sw, button : raw board inputs (synchronized internally)
//   led        : registered LED drive
//   dig_en     : registered digit enables, active-low
//   dig_seg    : registered segments {DP,G..A}, active-low
//
// Build option:
//   DIG_SCAN_EN defined   -> display scanner and hex decoder are built.
//   DIG_SCAN_EN undefined -> dig_en/dig_seg are tied to 8'hFF; the DIG
//                            register stays readable and writable.
// ---------------------------------------------------------------------------
module io_bridge #(
  parameter int unsigned SCAN_DIV  = 20000,
  parameter logic [31:0] TIMER_RST = 32'h0
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  io_bridge_if.slave  bus,
  output logic [13:0] dram_addr,
  output logic        dram_we,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  button,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam logic [31:0] ADDR_DIG  = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TCNT = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_TDIV = 32'hFFFF_F024;
  localparam logic [31:0] ADDR_LED  = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW   = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_BTN  = 32'hFFFF_F078;
  localparam logic [31:0] IO_BASE   = 32'hFFFF_F000;

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  logic is_dram_s;
  logic wr_dig_s;
  logic wr_tcnt_s;
  logic wr_tdiv_s;
  logic wr_led_s;

  assign is_dram_s = (bus.Bus_addr < IO_BASE);
  assign wr_dig_s  = bus.Bus_wen & (bus.Bus_addr == ADDR_DIG);
  assign wr_tcnt_s = bus.Bus_wen & (bus.Bus_addr == ADDR_TCNT);
  assign wr_tdiv_s = bus.Bus_wen & (bus.Bus_addr == ADDR_TDIV);
  assign wr_led_s  = bus.Bus_wen & (bus.Bus_addr == ADDR_LED);

  assign dram_addr  = bus.Bus_addr[15:2];
  assign dram_we    = bus.Bus_wen & is_dram_s;
  assign dram_wdata = bus.Bus_wdata;

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  logic [23:0] led_q,      led_d;
  logic [31:0] dig_q,      dig_d;
  logic [31:0] tcnt_q,     tcnt_d;
  logic [31:0] tdiv_q,     tdiv_d;
  logic [31:0] presc_q,    presc_d;
  logic [23:0] sw_meta_q,  sw_sync_q;
  logic [4:0]  btn_meta_q, btn_sync_q;

  // Two-flop synchronizers for the asynchronous board inputs
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      sw_meta_q  <= 24'h0;
      sw_sync_q  <= 24'h0;
      btn_meta_q <= 5'h0;
      btn_sync_q <= 5'h0;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= button;
      btn_sync_q <= btn_meta_q;
    end
  end

  // Next state for the writable registers and the timer
  always_comb begin
    led_d   = led_q;
    dig_d   = dig_q;
    tcnt_d  = tcnt_q;
    tdiv_d  = tdiv_q;
    presc_d = presc_q;

    if (wr_led_s) begin
      led_d = bus.Bus_wdata[23:0];
    end else begin
      led_d = led_q;
    end

    if (wr_dig_s) begin
      dig_d = bus.Bus_wdata;
    end else begin
      dig_d = dig_q;
    end

    // A write to either timer register overrides any tick in that cycle
    // and restarts the prescaler from zero.
    if (wr_tcnt_s || wr_tdiv_s) begin
      presc_d = 32'h0;
      if (wr_tcnt_s) begin
        tcnt_d = bus.Bus_wdata;
      end else begin
        tcnt_d = tcnt_q;
      end
      if (wr_tdiv_s) begin
        tdiv_d = bus.Bus_wdata;
      end else begin
        tdiv_d = tdiv_q;
      end
    end else if (tdiv_q != 32'h0) begin
      if (presc_q == (tdiv_q - 32'd1)) begin
        presc_d = 32'h0;
        tcnt_d  = tcnt_q + 32'd1;
      end else begin
        presc_d = presc_q + 32'd1;
        tcnt_d  = tcnt_q;
      end
    end else begin
      presc_d = presc_q;
      tcnt_d  = tcnt_q;
    end
  end

  // Register bank: LED, DIG, timer count, divider and prescaler
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      led_q   <= 24'h0;
      dig_q   <= 32'h0;
      tcnt_q  <= TIMER_RST;
      tdiv_q  <= 32'h0;
      presc_q <= 32'h0;
    end else begin
      led_q   <= led_d;
      dig_q   <= dig_d;
      tcnt_q  <= tcnt_d;
      tdiv_q  <= tdiv_d;
      presc_q <= presc_d;
    end
  end

  assign led = led_q;

  // ------------------------------------------------------------------
  // Combinational read mux
  // ------------------------------------------------------------------
  logic [31:0] rdata_s;

  // Select load data; unmapped I/O addresses read as zero
  always_comb begin
    rdata_s = 32'h0;
    if (is_dram_s) begin
      rdata_s = dram_rdata;
    end else begin
      case (bus.Bus_addr)
        ADDR_DIG:  rdata_s = dig_q;
        ADDR_TCNT: rdata_s = tcnt_q;
        ADDR_TDIV: rdata_s = tdiv_q;
        ADDR_LED:  rdata_s = {8'h0, led_q};
        ADDR_SW:   rdata_s = {8'h0, sw_sync_q};
        ADDR_BTN:  rdata_s = {27'h0, btn_sync_q};
        default:   rdata_s = 32'h0;
      endcase
    end
  end

  assign bus.Bus_rdata = rdata_s;

  // ------------------------------------------------------------------
  // 7-segment display scanner
  // ------------------------------------------------------------------
`ifdef DIG_SCAN_EN
  localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);

  // Active-low {DP,G..A} pattern for one hex nibble, DP off
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  logic [31:0] scan_q,   scan_d;
  logic [2:0]  idx_q,    idx_d;
  logic [7:0]  dig_en_q, dig_en_d;
  logic [7:0]  seg_q,    seg_d;

  // On each scan wrap, light the digit at idx and then step idx, so the
  // display stays dark until the first wrap after reset.
  always_comb begin
    scan_d   = scan_q;
    idx_d    = idx_q;
    dig_en_d = dig_en_q;
    seg_d    = seg_q;
    if (scan_q == SCAN_LAST) begin
      scan_d   = 32'h0;
      idx_d    = idx_q + 3'd1;
      dig_en_d = ~(8'h01 << idx_q);
      seg_d    = hex_seg(dig_q[{idx_q, 2'b00} +: 4]);
    end else begin
      scan_d   = scan_q + 32'd1;
      idx_d    = idx_q;
      dig_en_d = dig_en_q;
      seg_d    = seg_q;
    end
  end

  // Scan counter, digit index and registered display drive
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      scan_q   <= 32'h0;
      idx_q    <= 3'd0;
      dig_en_q <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      dig_en_q <= dig_en_d;
      seg_q    <= seg_d;
    end
  end

  assign dig_en  = dig_en_q;
  assign dig_seg = seg_q;
`else
  assign dig_en  = 8'hFF;
  assign dig_seg = 8'hFF;
`endif

endmodule : io_bridge

// File: tb/tb_io_bridge.sv
// ---------------------------------------------------------------------------
// tb_io_bridge
// Directed-vector bench for io_bridge. Drives the bus through an
// io_bridge_if instance, models one DRAM word plus a fixed background
// pattern, and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] dram_addr;
  logic        dram_we;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw = 24'h0;
  logic [4:0]  button = 5'h0;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;
  logic [31:0] word40;

  int n_vec = 0;
  int n_err = 0;

  io_bridge_if bus_if ();

  io_bridge #(
    .SCAN_DIV (4),
    .TIMER_RST(32'h0000_00C3)
  ) dut (
    .cpu_clk   (clk),
    .cpu_rst   (rst_n),
    .bus       (bus_if),
    .dram_addr (dram_addr),
    .dram_we   (dram_we),
    .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata),
    .sw        (sw),
    .button    (button),
    .led       (led),
    .dig_en    (dig_en),
    .dig_seg   (dig_seg)
  );

  always #5 clk = ~clk;

  // DRAM model: word 0x010 is writable, everything else reads a fixed pattern
  always @(posedge clk) begin
    if (dram_we && dram_addr == 14'h010) word40 <= dram_wdata;
  end
  assign dram_rdata = (dram_addr == 14'h010) ? word40 : 32'hDEAD_BEEF;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.Bus_addr  = a;
    bus_if.Bus_wdata = d;
    bus_if.Bus_wen   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.Bus_wen   = 1'b0;
  endtask

  task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_if.Bus_addr = a;
    #1;
    check_vec(tag, bus_if.Bus_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus_if.Bus_addr  = 32'h0;
    bus_if.Bus_wdata = 32'h0;
    bus_if.Bus_wen   = 1'b0;

    // ---------------- reset state ----------------
    #12;
    check_vec("rst_led", {8'h0, led}, 32'h0);
    check_vec("rst_dig_en", {24'h0, dig_en}, 32'hFF);
    check_vec("rst_dig_seg", {24'h0, dig_seg}, 32'hFF);
    bus_rd("rst_tcnt", 32'hFFFF_F020, 32'h0000_00C3);
    bus_rd("rst_tdiv", 32'hFFFF_F024, 32'h0);
    #2 rst_n = 1'b1;
    cyc(1);

    // ---------------- DRAM and LED ----------------
    bus_if.Bus_addr  = 32'h0000_0040;
    bus_if.Bus_wdata = 32'h1234_5678;
    bus_if.Bus_wen   = 1'b1;
    #1;
    check_vec("dram_we_store", {31'h0, dram_we}, 32'h1);
    check_vec("dram_addr", {18'h0, dram_addr}, 32'h10);
    check_vec("dram_wdata", dram_wdata, 32'h1234_5678);
    @(posedge clk); #1;
    bus_if.Bus_wen = 1'b0;
    #1;
    check_vec("dram_we_idle", {31'h0, dram_we}, 32'h0);
    bus_rd("dram_load", 32'h0000_0040, 32'h1234_5678);
    bus_if.Bus_addr  = 32'hFFFF_F060;
    bus_if.Bus_wen   = 1'b1;
    #1;
    check_vec("dram_we_led", {31'h0, dram_we}, 32'h0);
    @(posedge clk); #1;
    bus_if.Bus_wen = 1'b0;
    check_vec("led_out", {8'h0, led}, 32'h0034_5678);
    bus_rd("led_read", 32'hFFFF_F060, 32'h0034_5678);

    // ---------------- synchronizers ----------------
    bus_if.Bus_addr = 32'hFFFF_F070;
    sw     = 24'hABCDEF;
    button = 5'h15;
    #1;
    check_vec("sw_edge0", bus_if.Bus_rdata, 32'h0);
    cyc(1);
    check_vec("sw_edge1", bus_if.Bus_rdata, 32'h0);
    cyc(1);
    check_vec("sw_edge2", bus_if.Bus_rdata, 32'h00AB_CDEF);
    bus_rd("btn_read", 32'hFFFF_F078, 32'h0000_0015);

    // ---------------- read-only and unmapped ----------------
    bus_if.Bus_addr  = 32'hFFFF_F070;
    bus_if.Bus_wdata = 32'hFFFF_FFFF;
    bus_if.Bus_wen   = 1'b1;
    #1;
    check_vec("dram_we_sw", {31'h0, dram_we}, 32'h0);
    @(posedge clk); #1;
    bus_if.Bus_wen = 1'b0;
    bus_rd("sw_after_st", 32'hFFFF_F070, 32'h00AB_CDEF);
    check_vec("led_after_st", {8'h0, led}, 32'h0034_5678);
    bus_rd("unmapped_rd", 32'hFFFF_F100, 32'h0);
    bus_if.Bus_wen = 1'b1;
    #1;
    check_vec("dram_we_unm", {31'h0, dram_we}, 32'h0);
    @(posedge clk); #1;
    bus_if.Bus_wen = 1'b0;
    bus_rd("dig_after_unm", 32'hFFFF_F000, 32'h0);

    // ---------------- timer ----------------
    bus_wr(32'hFFFF_F024, 32'd3);
    bus_wr(32'hFFFF_F020, 32'hFFFF_FFFE);
    bus_rd("tcnt_load", 32'hFFFF_F020, 32'hFFFF_FFFE);
    cyc(2);
    check_vec("tcnt_c2", bus_if.Bus_rdata, 32'hFFFF_FFFE);
    cyc(1);
    check_vec("tcnt_c3", bus_if.Bus_rdata, 32'hFFFF_FFFF);
    cyc(3);
    check_vec("tcnt_wrap", bus_if.Bus_rdata, 32'h0);
    cyc(2);
    bus_wr(32'hFFFF_F020, 32'h0000_0055);
    bus_rd("tcnt_wr_tick", 32'hFFFF_F020, 32'h0000_0055);
    cyc(3);
    check_vec("tcnt_after", bus_if.Bus_rdata, 32'h0000_0056);
    bus_rd("tdiv_read", 32'hFFFF_F024, 32'd3);
    bus_wr(32'hFFFF_F024, 32'd0);
    bus_if.Bus_addr = 32'hFFFF_F020;
    cyc(7);
    check_vec("tcnt_hold", bus_if.Bus_rdata, 32'h0000_0056);

    // ---------------- display ----------------
    bus_wr(32'hFFFF_F000, 32'h0000_00A1);
    bus_rd("dig_read", 32'hFFFF_F000, 32'h0000_00A1);
`ifdef DIG_SCAN_EN
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (dig_en != 8'hFE) found = 1'b1;
      else cyc(1);
    end
    check_vec("scan_leave_fe", {31'h0, found}, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1);
      if (dig_en == 8'hFE) found = 1'b1;
    end
    check_vec("scan_find_fe", {31'h0, found}, 32'h1);
    check_vec("seg_d0", {24'h0, dig_seg}, 32'hF9);
    cyc(3);
    check_vec("en_hold", {24'h0, dig_en}, 32'hFE);
    cyc(1);
    check_vec("en_d1", {24'h0, dig_en}, 32'hFD);
    check_vec("seg_d1", {24'h0, dig_seg}, 32'h88);
    cyc(4);
    check_vec("en_d2", {24'h0, dig_en}, 32'hFB);
    check_vec("seg_d2", {24'h0, dig_seg}, 32'hC0);
    cyc(4);
    check_vec("en_d3", {24'h0, dig_en}, 32'hF7);
    check_vec("seg_d3", {24'h0, dig_seg}, 32'hC0);
    cyc(16);
    check_vec("en_d7", {24'h0, dig_en}, 32'h7F);
    cyc(4);
    check_vec("en_wrap", {24'h0, dig_en}, 32'hFE);
    check_vec("seg_wrap", {24'h0, dig_seg}, 32'hF9);
`else
    for (int i = 0; i < 4; i++) begin
      cyc(5);
      check_vec("en_tied", {24'h0, dig_en}, 32'hFF);
      check_vec("seg_tied", {24'h0, dig_seg}, 32'hFF);
    end
`endif

    // ---------------- asynchronous reset mid-store ----------------
    bus_wr(32'hFFFF_F024, 32'd1);
    cyc(2);
    bus_if.Bus_addr  = 32'hFFFF_F060;
    bus_if.Bus_wdata = 32'h0000_0777;
    bus_if.Bus_wen   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_vec("arst_led", {8'h0, led}, 32'h0);
    check_vec("arst_dig_en", {24'h0, dig_en}, 32'hFF);
    check_vec("arst_dig_seg", {24'h0, dig_seg}, 32'hFF);
    check_vec("arst_dram_we", {31'h0, dram_we}, 32'h0);
    bus_rd("arst_tcnt", 32'hFFFF_F020, 32'h0000_00C3);
    bus_rd("arst_dig", 32'hFFFF_F000, 32'h0);
    bus_rd("arst_sw", 32'hFFFF_F070, 32'h0);
    @(posedge clk); #1;
    bus_if.Bus_wen = 1'b0;
    #3 rst_n = 1'b1;
    cyc(3);
    check_vec("post_led", {8'h0, led}, 32'h0);
    bus_rd("post_tcnt", 32'hFFFF_F020, 32'h0000_00C3);
    bus_rd("post_tdiv", 32'hFFFF_F024, 32'h0);
    bus_rd("post_sw", 32'hFFFF_F070, 32'h00AB_CDEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_io_bridge

// File: doc/io_bridge.md
# io_bridge

Memory-mapped bus bridge between the pipelined CPU's MEM-stage data port (Bus_addr/Bus_rdata/Bus_wen/Bus_wdata) and the board-level resources: data RAM, LEDs, switches, buttons, a 7-segment display and a programmable timer. Address decode and read data are combinational, so a load completes in the CPU's MEM cycle. All peripheral state is registered on cpu_clk. The block is the direct downstream consumer of the CPU's bus signals.

## Interface
Parameters:
- SCAN_DIV, 20000: cpu_clk cycles each 7-seg digit stays lit.
- TIMER_RST, 32'h0: reset value of the timer count register.

Ports (one clock; reset is asynchronous and active-low):
- cpu_clk  in  1  system clock.
- cpu_rst  in  1  asynchronous reset, active-low.
- Bus_addr  in  32  byte address from the CPU MEM stage.
- Bus_wen  in  1  write strobe, one cycle per store.
- Bus_wdata  in  32  store data.
- Bus_rdata  out  32  load data, combinational.
- dram_addr  out  14  word address, equal to Bus_addr[15:2].
- dram_we  out  1  DRAM write enable.
- dram_wdata  out  32  equal to Bus_wdata.
- dram_rdata  in  32  DRAM read data, asynchronous.
- sw  in  24  switches.
- button  in  5  push buttons.
- led  out  24  LED drive, registered.
- dig_en  out  8  digit enables, active-low, registered.
- dig_seg  out  8  segments {DP,G..A}, active-low, registered.

## Operation
Address map (full 32-bit compare):
- 0xFFFF_F000 DIG: read/write, 8 hex digits, digit 0 = [3:0].
- 0xFFFF_F020 TCNT: read/write timer count.
- 0xFFFF_F024 TDIV: read/write prescaler threshold.
- 0xFFFF_F060 LED: read/write, [23:0].
- 0xFFFF_F070 SW: read-only, synchronized sw, zero-extended.
- 0xFFFF_F078 BTN: read-only, synchronized button, zero-extended.
- Any address below 0xFFFF_F000 is DRAM.
- Any other 0xFFFF_Fxxx address is unmapped: reads return 0 and writes are dropped.

Write rules:
- dram_we = Bus_wen & DRAM region.
- Stores to peripheral, read-only or unmapped addresses never assert dram_we.
- Stores to SW/BTN are ignored.

Synchronizers: sw and button each pass through 2 flops. Reset value is 0.

Timer:
- When TDIV == 0, the prescaler and TCNT hold.
- Otherwise the prescaler counts 0..TDIV-1. On the cycle it equals TDIV-1 it returns to 0 and TCNT increments, wrapping 0xFFFF_FFFF to 0.
- A write to TCNT or TDIV loads the register and clears the prescaler.
- If a write and a tick happen in the same cycle, the write wins.

Display:
- The scan counter counts 0..SCAN_DIV-1. At wrap, the digit index advances 0..7 and wraps.
- dig_en = ~(8'b1 << idx).
- dig_seg = hex decode of DIG[4*idx+3:4*idx], with DP off (bit 7 = 1).

## Timing
- Bus_rdata is valid in the same cycle as Bus_addr. It has no wait states.
- Register writes take effect at the cpu_clk edge where Bus_wen = 1. A read in the following cycle returns the new value.
- A sw/button change is readable 2 edges later.
- Reset (cpu_rst = 0, asynchronous) sets: led = 0, DIG = 0, TCNT = TIMER_RST, TDIV = 0, prescaler = 0, idx = 0, scan counter = 0, dig_en = 8'hFF, dig_seg = 8'hFF, synchronizers = 0.
- The first digit lights on the first scan wrap after reset release.
- Reset asserted mid-store discards the store.
- Reset release is not synchronized inside this block.

## Configuration
- DIG_SCAN_EN defined: the scanner and decoder are built as described above.
- DIG_SCAN_EN undefined: the scanner is removed and dig_en/dig_seg are tied to 8'hFF. The DIG register remains readable and writable.

## Test plan
- Store 0x1234_5678 to 0x0000_0040, then load from it -> dram_we = 1 for one cycle, dram_addr = 0x010, Bus_rdata = 0x1234_5678. Then store to 0xFFFF_F060 -> dram_we stays 0 and led = 0x34_5678.
- sw = 0xABCDEF -> Bus_rdata at 0xFFFF_F070 is 0 for 2 edges, then 0x00AB_CDEF. Store to 0xFFFF_F070 -> no effect on anything. Load from 0xFFFF_F100 -> 0.
- TDIV = 3, TCNT = 0xFFFF_FFFE -> TCNT = 0xFFFF_FFFF after 3 cycles and 0 after 6. A TCNT write on a tick cycle loads the written value.
- SCAN_DIV = 4, DIG = 0x0000_00A1 -> dig_en steps FE, FD, FB, … every 4 cycles. Digit 0 shows "1" (dig_seg = 8'hF9), digit 1 shows "A" (8'h88), higher digits show "0" (8'hC0).
- Drop cpu_rst mid-scan with TDIV ≠ 0 -> every output immediately takes its reset value. After release, TCNT = TIMER_RST and TDIV reads 0.
- Build without DIG_SCAN_EN -> dig_en = dig_seg = 8'hFF permanently, and a DIG write/readback still works.
